fifo_arbiter_ctrl: RTL and testbench
====================================

Name: fifo_arbiter_ctrl

Overview:
Controller and round-robin arbiter between NUM_Q source FIFO_mod instances and NUM_Q destination FIFO_mod instances.
- Pops at most one word per cycle from a non-empty source and pushes it to the destination FIFO selected by the word's dest field.
- Stalls on any destination pause.
- Owns the umbralA/umbralB threshold configuration for all FIFOs through an init/idle/active/error FSM.

Parameters:
- BUS_SIZE, 5: data word width; dest field is bits [BUS_SIZE-1 -: SEL_W].
- NUM_Q, 4: number of source and destination queues (power of 2, ≥2).
- SEL_W, $clog2(NUM_Q): width of the dest field and grant index (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  configuration request; thresholds are latched while high.
- umbral_a_in  in  4  almost-full threshold to load.
- umbral_b_in  in  4  almost-empty threshold to load.
- src_empty  in  NUM_Q  empty flags from the source FIFOs.
- src_data  in  NUM_Q*BUS_SIZE  data_out of the source FIFOs, queue i at [i*BUS_SIZE +: BUS_SIZE].
- dst_pause  in  NUM_Q  pause (almost_full) flags from the destination FIFOs.
- fifo_err  in  2*NUM_Q  fifo_error flags from all FIFOs.
- src_pop  out  NUM_Q  one-hot pop strobe to the sources.
- dst_push  out  NUM_Q  one-hot push strobe to the destinations.
- dst_data  out  BUS_SIZE  word to the destinations.
- umbral_a  out  4  registered threshold driven to all FIFOs.
- umbral_b  out  4  registered threshold driven to all FIFOs.
- idle  out  1  high in IDLE state.
- error_out  out  1  high in ERROR state.

Behaviour:
- Reset (reset=0, asynchronous): state=RESET; src_pop=0, dst_push=0, dst_data=0, umbral_a=0, umbral_b=0, idle=0, error_out=0; grant pointer=NUM_Q-1; pipeline valid bits cleared. A reset mid-transfer discards in-flight words.
- FSM, one-hot encoded:
  - RESET → INIT on the first clock after reset is released.
  - INIT: umbral_a/umbral_b load umbral_a_in/umbral_b_in every cycle while init=1. When init=0 → IDLE.
  - IDLE: idle=1. If some src_empty bit is 0 → ACTIVE. If init=1 → INIT.
  - ACTIVE: arbitrates. When all sources are empty and the pipeline is empty → IDLE. If init=1, stop new pops, drain the pipeline, then → INIT.
  - ERROR: entered from any state except RESET when |fifo_err=1. Sticky until reset. No pops, pending pushes suppressed, error_out=1.
- Arbitration (ACTIVE, no pause):
  - Grant goes to the first i with src_empty[i]=0, scanning from ptr+1 cyclically.
  - src_pop[i]=1 for that cycle, then ptr←i.
  - At most one pop per cycle.
- Pause: if |dst_pause=1, no pop is issued that cycle. Words already in flight (at most 2) still push. Software must set umbralA ≤ depth−2.
- Pipeline, throughput one word per cycle:
  - Pop in cycle N.
  - Source data is valid in cycle N+1; the arbiter captures it together with its grant index.
  - Cycle N+2: dst_push[dest]=1 and dst_data=word, both registered.
- Simultaneous events: pop and push of different words in the same cycle are normal. A pause arriving while popping stops the next pop only. fifo_err has priority over init.
- No combinational path from src_empty or dst_pause to dst_push.

Optional Feature:
- Macro ARB_STRICT_PRIO_EN.
- Defined: strict priority; the lowest-index non-empty source always wins and the pointer is unused.
- Undefined: round-robin as specified above.

Decomposition:
- Package fifo_arb_pkg holds the state encoding constants (ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR) and the default threshold values.
- One sub-module, rr_grant: combinational round-robin picker taking request vector and pointer, returning one-hot grant and index.

Test Plan:
- Reset released, init=1 with umbral_a_in=6, umbral_b_in=1, then init=0 → umbral_a=6, umbral_b=1; state INIT→IDLE; idle=1.
- All four sources hold 2 words; dests all 0b00 → pop order 0,1,2,3,0,1,2,3; 8 pushes to dst_push[0], each 2 cycles after its pop.
- Source 2 holds word 5'b11010 → src_pop[2] in cycle N; cycle N+2 dst_push=4'b1000, dst_data=5'b11010.
- dst_pause[1]=1 for 3 cycles during a stream → no src_pop in those cycles; the ≤2 in-flight words still pushed; popping resumes the cycle after pause drops.
- fifo_err[5]=1 while ACTIVE → error_out=1 next cycle; no further pop/push until reset=0, which returns to RESET.
- With ARB_STRICT_PRIO_EN, sources 0 and 3 both non-empty → source 0 is drained fully before the first pop of source 3.

Source files
------------

// File: rtl/fifo_arbiter_ctrl_pkg.sv
// Shared definitions for the FIFO arbiter controller: one-hot state encoding
// and the threshold values the FIFOs see out of reset.
package fifo_arb_pkg;

  localparam int UMBRAL_W = 4;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam logic [UMBRAL_W-1:0] DEF_UMBRAL_A = 4'd0;
  localparam logic [UMBRAL_W-1:0] DEF_UMBRAL_B = 4'd0;

endpackage

// File: rtl/fifo_arbiter_ctrl_if.sv
// Bundle of every FIFO-facing signal of the arbiter controller; master is the
// controller side, slave is the FIFO array side.
interface fifo_arbiter_ctrl_if #(
  parameter int BUS_SIZE = 5,
  parameter int NUM_Q    = 4
);
  import fifo_arb_pkg::*;

  logic                      init;
  logic [UMBRAL_W-1:0]       umbral_a_in;
  logic [UMBRAL_W-1:0]       umbral_b_in;
  logic [NUM_Q-1:0]          src_empty;
  logic [NUM_Q*BUS_SIZE-1:0] src_data;
  logic [NUM_Q-1:0]          dst_pause;
  logic [2*NUM_Q-1:0]        fifo_err;
  logic [NUM_Q-1:0]          src_pop;
  logic [NUM_Q-1:0]          dst_push;
  logic [BUS_SIZE-1:0]       dst_data;
  logic [UMBRAL_W-1:0]       umbral_a;
  logic [UMBRAL_W-1:0]       umbral_b;
  logic                      idle;
  logic                      error_out;

  modport master (
    input  init, umbral_a_in, umbral_b_in, src_empty, src_data, dst_pause, fifo_err,
    output src_pop, dst_push, dst_data, umbral_a, umbral_b, idle, error_out
  );

  modport slave (
    output init, umbral_a_in, umbral_b_in, src_empty, src_data, dst_pause, fifo_err,
    input  src_pop, dst_push, dst_data, umbral_a, umbral_b, idle, error_out
  );

endinterface

// File: rtl/fifo_arbiter_ctrl_rr_grant.sv
// Combinational request picker: round-robin starting after ptr, or fixed
// lowest-index priority when ARB_STRICT_PRIO_EN is defined.
module rr_grant #(
  parameter  int NUM_Q = 4,
  localparam int SEL_W = $clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NUM_Q-1:0] grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [SEL_W-1:0] cand_idx [NUM_Q];
  logic [NUM_Q-1:0] cand_req;

  // Candidate gi is the queue examined gi-th in scan order.
  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_cand
`ifdef ARB_STRICT_PRIO_EN
      assign cand_idx[gi] = SEL_W'(gi);
`else
      assign cand_idx[gi] = ptr + SEL_W'(gi + 1);
`endif
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

`ifdef ARB_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_idx   = cand_idx[i];
        grant_valid = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_grant
      assign grant[gi] = grant_valid && (grant_idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_arbiter_ctrl.sv
// Source-to-destination FIFO arbiter with threshold configuration FSM.
// Define ARB_STRICT_PRIO_EN for strict lowest-index priority instead of round-robin.
module fifo_arbiter_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int BUS_SIZE = 5,
  parameter int NUM_Q    = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_arbiter_ctrl_if.master bus
);

  localparam int SEL_W = $clog2(NUM_Q);

  state_t              state_reg;
  state_t              state_next;
  logic [NUM_Q-1:0]    req;
  logic [NUM_Q-1:0]    grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [SEL_W-1:0]    ptr_reg;
  logic                pop_en;
  logic                s1_valid_reg;
  logic [SEL_W-1:0]    s1_idx_reg;
  logic [BUS_SIZE-1:0] s1_word;
  logic [SEL_W-1:0]    s1_dest;
  logic [NUM_Q-1:0]    push_reg;
  logic [NUM_Q-1:0]    push_next;
  logic [BUS_SIZE-1:0] data_reg;
  logic [UMBRAL_W-1:0] umbral_a_reg;
  logic [UMBRAL_W-1:0] umbral_b_reg;
  logic                err_any;
  logic                all_empty;
  logic                pipe_empty;

  assign req        = ~bus.src_empty;
  assign err_any    = |bus.fifo_err;
  assign all_empty  = &bus.src_empty;
  assign pipe_empty = !s1_valid_reg && !(|push_reg);

  rr_grant #(.NUM_Q(NUM_Q)) u_rr_grant (
    .req         (req),
    .ptr         (ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_RESET;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT:   if (!bus.init) state_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.init)        state_next = ST_INIT;
        else if (!all_empty) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // With init pending no new pops are issued, so waiting for an empty pipe drains it.
        if (bus.init && pipe_empty)                state_next = ST_INIT;
        else if (!bus.init && all_empty && pipe_empty) state_next = ST_IDLE;
      end
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_RESET;
    endcase
    if (state_reg != ST_RESET && err_any) state_next = ST_ERROR;
  end

  always_comb begin
    pop_en        = 1'b0;
    bus.idle      = 1'b0;
    bus.error_out = 1'b0;
    case (state_reg)
      ST_IDLE:   bus.idle = 1'b1;
      ST_ACTIVE: pop_en = grant_valid && !bus.init && !(|bus.dst_pause) && !err_any;
      ST_ERROR:  bus.error_out = 1'b1;
      default:   pop_en = 1'b0;
    endcase
    bus.src_pop = pop_en ? grant : '0;
  end

  // The source presents the popped word one cycle after the pop strobe.
  assign s1_word = bus.src_data[s1_idx_reg*BUS_SIZE +: BUS_SIZE];
  assign s1_dest = s1_word[BUS_SIZE-1 -: SEL_W];

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_push
      assign push_next[gi] = s1_valid_reg && (s1_dest == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg      <= SEL_W'(NUM_Q - 1);
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      push_reg     <= '0;
      data_reg     <= '0;
    end else begin
      if (pop_en) ptr_reg <= grant_idx;
      if (state_next == ST_ERROR) begin
        s1_valid_reg <= 1'b0;
        push_reg     <= '0;
      end else begin
        s1_valid_reg <= pop_en;
        if (pop_en) s1_idx_reg <= grant_idx;
        push_reg <= push_next;
        if (s1_valid_reg) data_reg <= s1_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      umbral_a_reg <= DEF_UMBRAL_A;
      umbral_b_reg <= DEF_UMBRAL_B;
    end else if (state_reg == ST_INIT && bus.init) begin
      umbral_a_reg <= bus.umbral_a_in;
      umbral_b_reg <= bus.umbral_b_in;
    end
  end

  assign bus.dst_push = push_reg;
  assign bus.dst_data = data_reg;
  assign bus.umbral_a = umbral_a_reg;
  assign bus.umbral_b = umbral_b_reg;

endmodule

// File: tb/tb_fifo_arbiter_ctrl.sv
// Bench for fifo_arbiter_ctrl: queue-backed source FIFO model plus a push scoreboard.
module tb_fifo_arbiter_ctrl;

  localparam int BUS_SIZE = 5;
  localparam int NUM_Q    = 4;

  typedef struct {
    int         due;
    logic [3:0] push;
    logic [4:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_arbiter_ctrl_if #(.BUS_SIZE(BUS_SIZE), .NUM_Q(NUM_Q)) bus ();

  fifo_arbiter_ctrl #(.BUS_SIZE(BUS_SIZE), .NUM_Q(NUM_Q)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       sb[$];
  exp_t       mon_e;
  logic [4:0] mon_w;
  logic [4:0] srcq[NUM_Q][$];
  logic [4:0] out_reg[NUM_Q];
  logic [NUM_Q-1:0] pend_pop = '0;
  int pop_log[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  // Monitor: compares pushes against the scoreboard and records pops.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en) begin
      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        if (bus.dst_push !== mon_e.push || bus.dst_data !== mon_e.data) begin
          errors++;
          $display("FAIL push_sb cyc=%0d got push=%b data=%b expected push=%b data=%b",
                   cyc, bus.dst_push, bus.dst_data, mon_e.push, mon_e.data);
        end
      end else if (bus.dst_push !== '0) begin
        errors++;
        $display("FAIL push_spurious cyc=%0d got push=%b expected 0000", cyc, bus.dst_push);
      end
    end
    if (bus.src_pop !== '0) begin
      checks++;
      if (!$onehot(bus.src_pop) || (|bus.dst_pause)) begin
        errors++;
        $display("FAIL pop_legal cyc=%0d got pop=%b pause=%b expected one-hot pop without pause",
                 cyc, bus.src_pop, bus.dst_pause);
      end
      for (int i = 0; i < NUM_Q; i++) begin
        if (bus.src_pop[i]) begin
          if (srcq[i].size() == 0) begin
            errors++;
            $display("FAIL pop_empty cyc=%0d got pop of src %0d expected no pop (empty)", cyc, i);
          end else begin
            mon_w      = srcq[i][0];
            mon_e.due  = cyc + 2;
            mon_e.push = 4'b0001 << mon_w[4:3];
            mon_e.data = mon_w;
            sb.push_back(mon_e);
            pop_log.push_back(i);
          end
        end
      end
    end
    pend_pop = bus.src_pop;
  end

  // Source FIFO model: data_out and empty update just after the clock edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_Q; i++) begin
      if (pend_pop[i] && srcq[i].size() > 0) out_reg[i] = srcq[i].pop_front();
      bus.src_empty[i] = (srcq[i].size() == 0);
      bus.src_data[i*BUS_SIZE +: BUS_SIZE] = out_reg[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0;
    bus.init = 1'b1;
    bus.umbral_a_in = 4'd6;
    bus.umbral_b_in = 4'd1;
    bus.dst_pause = '0;
    bus.fifo_err = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.src_pop !== 4'b0 || bus.dst_push !== 4'b0 || bus.dst_data !== 5'b0) begin
      errors++;
      $display("FAIL reset_data got pop=%b push=%b data=%b expected 0", bus.src_pop, bus.dst_push, bus.dst_data);
    end
    checks++;
    if (bus.umbral_a !== 4'd0 || bus.umbral_b !== 4'd0 || bus.idle !== 1'b0 || bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ua=%0d ub=%0d idle=%b err=%b expected 0", bus.umbral_a, bus.umbral_b, bus.idle, bus.error_out);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.idle !== 1'b0 || bus.umbral_a !== 4'd6 || bus.umbral_b !== 4'd1) begin
      errors++;
      $display("FAIL init_load got idle=%b ua=%0d ub=%0d expected idle=0 ua=6 ub=1", bus.idle, bus.umbral_a, bus.umbral_b);
    end
    bus.init = 1'b0;
    bus.umbral_a_in = 4'd9;
    @(negedge clk);
    checks++;
    if (bus.idle !== 1'b1 || bus.umbral_a !== 4'd6 || bus.umbral_b !== 4'd1) begin
      errors++;
      $display("FAIL init_idle got idle=%b ua=%0d ub=%0d expected idle=1 ua=6 ub=1", bus.idle, bus.umbral_a, bus.umbral_b);
    end
  endtask

  task automatic test_round_robin();
    int t;
    pop_log.delete();
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_Q; i++) srcq[i].push_back({2'b00, 3'(i * 2 + k)});
    for (t = 0; t < 100 && pop_log.size() < 8; t++) @(negedge clk);
    checks++;
    if (pop_log.size() != 8) begin
      errors++;
      $display("FAIL rr_count got %0d pops expected 8", pop_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (pop_log[k] != k % 4) begin
          errors++;
          $display("FAIL rr_order pop %0d got src %0d expected src %0d", k, pop_log[k], k % 4);
        end
      end
    end
    for (t = 0; t < 50 && !(bus.idle === 1'b1 && sb.size() == 0); t++) @(negedge clk);
    checks++;
    if (bus.idle !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain got idle=%b pending=%0d expected idle=1 pending=0", bus.idle, sb.size());
    end
  endtask

  task automatic test_single_word();
    int t;
    #1;
    srcq[2].push_back(5'b11010);
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.src_pop !== 4'b0) break;
    end
    checks++;
    if (bus.src_pop !== 4'b0100) begin
      errors++;
      $display("FAIL single_pop got pop=%b expected 0100", bus.src_pop);
    end
    @(negedge clk);
    checks++;
    if (bus.dst_push !== 4'b0000) begin
      errors++;
      $display("FAIL single_n1 got push=%b expected 0000", bus.dst_push);
    end
    @(negedge clk);
    checks++;
    if (bus.dst_push !== 4'b1000 || bus.dst_data !== 5'b11010) begin
      errors++;
      $display("FAIL single_n2 got push=%b data=%b expected push=1000 data=11010", bus.dst_push, bus.dst_data);
    end
    for (t = 0; t < 20 && bus.idle !== 1'b1; t++) @(negedge clk);
  endtask

  task automatic test_pause();
    int t;
    int run;
    int pushes;
    #1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NUM_Q; i++) srcq[i].push_back({2'((i + k) % 4), 3'(i * 3 + k)});
    run = 0;
    for (t = 0; t < 30 && run < 2; t++) begin
      @(negedge clk);
      if (bus.src_pop !== 4'b0) run++;
      else run = 0;
    end
    checks++;
    if (run < 2) begin
      errors++;
      $display("FAIL pause_stream got %0d consecutive pops expected 2", run);
    end
    @(posedge clk);
    #1 bus.dst_pause = 4'b0010;
    pushes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.src_pop !== 4'b0) begin
        errors++;
        $display("FAIL pause_pop cycle %0d got pop=%b expected 0000", c, bus.src_pop);
      end
      if (bus.dst_push !== 4'b0) pushes++;
    end
    checks++;
    if (pushes != 2) begin
      errors++;
      $display("FAIL pause_inflight got %0d pushes expected 2", pushes);
    end
    @(posedge clk);
    #1 bus.dst_pause = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.src_pop === 4'b0) begin
      errors++;
      $display("FAIL pause_resume got pop=%b expected a pop", bus.src_pop);
    end
    for (t = 0; t < 60 && !(bus.idle === 1'b1 && sb.size() == 0); t++) @(negedge clk);
    checks++;
    if (bus.idle !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL pause_drain got idle=%b pending=%0d expected idle=1 pending=0", bus.idle, sb.size());
    end
  endtask

  task automatic test_error();
    int t;
    #1;
    for (int k = 0; k < 6; k++) srcq[0].push_back({2'b01, 3'(k)});
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.src_pop !== 4'b0) break;
    end
    @(posedge clk);
    #1;
    bus.fifo_err = 8'b0010_0000;
    mon_en = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.error_out !== 1'b1 || bus.src_pop !== 4'b0 || bus.dst_push !== 4'b0) begin
      errors++;
      $display("FAIL err_enter got err=%b pop=%b push=%b expected err=1 pop=0 push=0", bus.error_out, bus.src_pop, bus.dst_push);
    end
    bus.fifo_err = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.error_out !== 1'b1 || bus.src_pop !== 4'b0 || bus.dst_push !== 4'b0 || bus.idle !== 1'b0) begin
        errors++;
        $display("FAIL err_sticky got err=%b pop=%b push=%b idle=%b expected err=1 pop=0 push=0 idle=0",
                 bus.error_out, bus.src_pop, bus.dst_push, bus.idle);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.error_out !== 1'b0 || bus.idle !== 1'b0 || bus.umbral_a !== 4'd0 || bus.dst_data !== 5'd0) begin
      errors++;
      $display("FAIL err_reset got err=%b idle=%b ua=%0d data=%b expected all 0", bus.error_out, bus.idle, bus.umbral_a, bus.dst_data);
    end
    for (int i = 0; i < NUM_Q; i++) srcq[i].delete();
    sb.delete();
    pop_log.delete();
    bus.init = 1'b1;
    bus.umbral_a_in = 4'hF;
    bus.umbral_b_in = 4'h3;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus.init = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.idle !== 1'b1 || bus.umbral_a !== 4'hF || bus.umbral_b !== 4'h3) begin
      errors++;
      $display("FAIL reinit got idle=%b ua=%0d ub=%0d expected idle=1 ua=15 ub=3", bus.idle, bus.umbral_a, bus.umbral_b);
    end
  endtask

  task automatic test_priority();
    int t;
    int exp_order[6];
`ifdef ARB_STRICT_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0;
    exp_order[3] = 3; exp_order[4] = 3; exp_order[5] = 3;
`else
    exp_order[0] = 0; exp_order[1] = 3; exp_order[2] = 0;
    exp_order[3] = 3; exp_order[4] = 0; exp_order[5] = 3;
`endif
    pop_log.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      srcq[0].push_back({2'b10, 3'(k)});
      srcq[3].push_back({2'b01, 3'(k + 4)});
    end
    for (t = 0; t < 50 && pop_log.size() < 6; t++) @(negedge clk);
    checks++;
    if (pop_log.size() != 6) begin
      errors++;
      $display("FAIL prio_count got %0d pops expected 6", pop_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (pop_log[k] != exp_order[k]) begin
          errors++;
          $display("FAIL prio_order pop %0d got src %0d expected src %0d", k, pop_log[k], exp_order[k]);
        end
      end
    end
    for (t = 0; t < 30 && !(bus.idle === 1'b1 && sb.size() == 0); t++) @(negedge clk);
    checks++;
    if (bus.idle !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL prio_drain got idle=%b pending=%0d expected idle=1 pending=0", bus.idle, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_word();
    test_pause();
    test_error();
    test_priority();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
